// File: rtl/e203_exu_wbck_buf_pkg.sv
// Shared widths and the writeback request record for the writeback buffer.
package e203_wbck_pkg;
  localparam int XLEN    = 32;
  localparam int RFIDX_W = 5;

  typedef struct packed {
    logic [RFIDX_W-1:0] idx;
    logic [XLEN-1:0]    dat;
  } wbck_req_t;
endpackage

// File: rtl/e203_exu_wbck_buf_if.sv
// Handshake bundle between the ALU / long-pipe producers, the writeback buffer
// and the regfile write port. master = producer/consumer side, slave = buffer.
interface e203_exu_wbck_buf_if #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5
);
  logic               alu_wbck_valid;
  logic               alu_wbck_ready;
  logic [RFIDX_W-1:0] alu_wbck_idx;
  logic [XLEN-1:0]    alu_wbck_dat;
  logic               lp_wbck_valid;
  logic               lp_wbck_ready;
  logic [RFIDX_W-1:0] lp_wbck_idx;
  logic [XLEN-1:0]    lp_wbck_dat;
  logic               wbck_dest_wen;
  logic [RFIDX_W-1:0] wbck_dest_idx;
  logic [XLEN-1:0]    wbck_dest_dat;
  logic               wbck_busy;

  modport master (
    output alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
    output lp_wbck_valid, lp_wbck_idx, lp_wbck_dat,
    input  alu_wbck_ready, lp_wbck_ready,
    input  wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, wbck_busy
  );

  modport slave (
    input  alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
    input  lp_wbck_valid, lp_wbck_idx, lp_wbck_dat,
    output alu_wbck_ready, lp_wbck_ready,
    output wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, wbck_busy
  );
endinterface

// File: rtl/e203_exu_wbck_buf_fifo.sv
// Synchronous FIFO holding long-pipe writeback requests in acceptance order.
// DEPTH must be a power of two so the pointers wrap naturally.
module e203_wbck_fifo
  import e203_wbck_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type req_t = wbck_req_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  req_t          push_dat,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output req_t          head
);
  req_t          mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          push_en, pop_en;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rptr_q];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wptr_q] <= push_dat;
  end

  // Pointers and occupancy; simultaneous push+pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + AW'(1);
      if (pop_en)  rptr_q <= rptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/e203_exu_wbck_buf.sv
// Writeback producer for the integer regfile write port. Buffered long-pipe
// results have strict priority over single-cycle ALU results; the regfile
// write outputs are registered. Optional same-cycle forwarding of the pending
// write is enabled by defining E203_WBCK_FWD_EN.
module e203_exu_wbck_buf
  import e203_wbck_pkg::*;
#(
  parameter int  XLEN     = e203_wbck_pkg::XLEN,
  parameter int  RFIDX_W  = e203_wbck_pkg::RFIDX_W,
  parameter int  LP_DEPTH = 2,
  localparam int CW       = $clog2(LP_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  e203_exu_wbck_buf_if.slave   bus
`ifdef E203_WBCK_FWD_EN
  ,
  input  logic [RFIDX_W-1:0]   fwd_idx,
  output logic                 fwd_hit,
  output logic [XLEN-1:0]      fwd_dat
`endif
);
  typedef struct packed {
    logic [RFIDX_W-1:0] idx;
    logic [XLEN-1:0]    dat;
  } req_t;

  req_t               lp_req, head, sel_d;
  logic               full, empty, sel_valid_d;
  logic [CW-1:0]      count;
  logic               wen_q;
  logic [RFIDX_W-1:0] idx_q;
  logic [XLEN-1:0]    dat_q;

  assign lp_req = '{idx: bus.lp_wbck_idx, dat: bus.lp_wbck_dat};

  // Long-pipe results always go through the FIFO, so a full FIFO blocks the
  // producer even on a cycle where the head is being popped.
  e203_wbck_fifo #(
    .DEPTH (LP_DEPTH),
    .req_t (req_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.lp_wbck_valid),
    .push_dat (lp_req),
    .pop      (!empty),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .head     (head)
  );

  assign bus.lp_wbck_ready  = !full;
  assign bus.alu_wbck_ready = empty;

  // Select the result to commit: FIFO head first, ALU only when FIFO is empty.
  always_comb begin
    sel_valid_d = 1'b0;
    sel_d       = '0;
    if (!empty) begin
      sel_valid_d = 1'b1;
      sel_d       = head;
    end else if (bus.alu_wbck_valid) begin
      sel_valid_d = 1'b1;
      sel_d       = '{idx: bus.alu_wbck_idx, dat: bus.alu_wbck_dat};
    end
  end

  // Output register; x0 targets are consumed without raising the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q <= 1'b0;
      idx_q <= '0;
      dat_q <= '0;
    end else begin
      wen_q <= sel_valid_d && (sel_d.idx != '0);
      if (sel_valid_d) begin
        idx_q <= sel_d.idx;
        dat_q <= sel_d.dat;
      end
    end
  end

  assign bus.wbck_dest_wen = wen_q;
  assign bus.wbck_dest_idx = idx_q;
  assign bus.wbck_dest_dat = dat_q;
  assign bus.wbck_busy     = (count != '0) || wen_q;

`ifdef E203_WBCK_FWD_EN
  // Expose the write that commits at the next edge to same-cycle readers.
  assign fwd_hit = wen_q && (fwd_idx == idx_q) && (fwd_idx != '0);
  assign fwd_dat = fwd_hit ? dat_q : '0;
`endif
endmodule
